// File: rtl/boot_pkg.sv
// Shared types and widths for the boot/run sequencer.
package boot_pkg;

   localparam int BOOT_DEPTH = 256;
   localparam int W_ADDR     = $clog2(BOOT_DEPTH);
   localparam int W_CNT      = W_ADDR + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_LO,
      S_LOAD_HI,
      S_START,
      S_RUN,
      S_DUMP_RD,
      S_DUMP_OUT
   } boot_state_e;

endpackage

// File: rtl/boot_ctrl_mux.sv
// Grant mux for the IRAM/DRAM ports: controller owns them except while the CPU runs.
module ram_port_mux
   import boot_pkg::*;
#(
   parameter int W_INSTR = 16,
   parameter int W_DATA  = 8
) (
   input  logic               grant_cpu_i,
   input  logic [W_ADDR-1:0]  ctrl_iram_addr_i,
   input  logic               ctrl_iram_we_i,
   input  logic [W_INSTR-1:0] ctrl_iram_din_i,
   input  logic [W_ADDR-1:0]  ctrl_dram_addr_i,
   input  logic               ctrl_dram_write_i,
   input  logic [W_DATA-1:0]  ctrl_dram_din_i,
   input  logic [W_ADDR-1:0]  cpu_iram_addr_i,
   input  logic [W_ADDR-1:0]  cpu_dram_addr_i,
   input  logic [W_DATA-1:0]  cpu_dram_din_i,
   input  logic               cpu_dram_write_i,
   output logic [W_ADDR-1:0]  iram_addr_o,
   output logic               iram_we_o,
   output logic [W_INSTR-1:0] iram_din_o,
   output logic [W_ADDR-1:0]  dram_addr_o,
   output logic               dram_write_o,
   output logic [W_DATA-1:0]  dram_din_o
);

   // The CPU never writes IRAM, so its write enable is forced low under grant.
   always_comb begin
      iram_din_o = ctrl_iram_din_i;
      if (grant_cpu_i) begin
         iram_addr_o  = cpu_iram_addr_i;
         iram_we_o    = 1'b0;
         dram_addr_o  = cpu_dram_addr_i;
         dram_write_o = cpu_dram_write_i;
         dram_din_o   = cpu_dram_din_i;
      end else begin
         iram_addr_o  = ctrl_iram_addr_i;
         iram_we_o    = ctrl_iram_we_i;
         dram_addr_o  = ctrl_dram_addr_i;
         dram_write_o = ctrl_dram_write_i;
         dram_din_o   = ctrl_dram_din_i;
      end
   end

endmodule

// File: rtl/boot_ctrl.sv
// Boot sequencer: loads IRAM from the host stream, runs the CPU, then dumps DRAM.
module boot_ctrl
   import boot_pkg::*;
#(
   parameter int W_INSTR = 16,
   parameter int W_DATA  = 8,
   parameter int DEPTH   = 256
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [W_DATA-1:0]  s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [W_DATA-1:0]  m_data,
   output logic               cpu_start,
   input  logic               cpu_idle,
   input  logic [W_ADDR-1:0]  cpu_iram_addr,
   input  logic [W_ADDR-1:0]  cpu_dram_addr,
   input  logic [W_DATA-1:0]  cpu_dram_din,
   input  logic               cpu_dram_write,
   output logic [W_ADDR-1:0]  iram_addr,
   output logic               iram_we,
   output logic [W_INSTR-1:0] iram_din,
   output logic [W_ADDR-1:0]  dram_addr,
   output logic               dram_write,
   output logic [W_DATA-1:0]  dram_din,
   input  logic [W_DATA-1:0]  dram_dout,
   output logic               busy,
   output logic               done
);

   localparam logic [W_CNT-1:0] LAST_ADDR = W_CNT'(DEPTH - 1);

   boot_state_e       state_q;
   logic [W_CNT-1:0]  k_q;
   logic [W_CNT-1:0]  n_q;
   logic [W_DATA-1:0] lo_q;
   logic              run_seen_q;
   logic              done_q;
   logic              s_xfer;
   logic              grant_cpu;

   assign s_ready   = (state_q == S_IDLE) || (state_q == S_LOAD_LO) || (state_q == S_LOAD_HI);
   assign s_xfer    = s_valid && s_ready;
   assign m_valid   = (state_q == S_DUMP_OUT);
   assign m_data    = dram_dout;
   assign cpu_start = (state_q == S_START);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign grant_cpu = (state_q == S_START) || (state_q == S_RUN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         n_q        <= '0;
         lo_q       <= '0;
         run_seen_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (s_xfer) begin
                  // A zero count byte stands for a full 256-word image.
                  n_q     <= (s_data == '0) ? {1'b1, {W_ADDR{1'b0}}} : {1'b0, s_data};
                  k_q     <= '0;
                  state_q <= S_LOAD_LO;
               end
            end
            S_LOAD_LO: begin
               if (s_xfer) begin
                  lo_q    <= s_data;
                  state_q <= S_LOAD_HI;
               end
            end
            S_LOAD_HI: begin
               if (s_xfer) begin
                  if (k_q == n_q - 1'b1) begin
                     k_q     <= '0;
                     state_q <= S_START;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     state_q <= S_LOAD_LO;
                  end
               end
            end
            S_START: begin
               run_seen_q <= 1'b0;
               state_q    <= S_RUN;
            end
            S_RUN: begin
               // First RUN cycle ignores a stale idle left over from the previous program.
               run_seen_q <= 1'b1;
               if (run_seen_q && cpu_idle) begin
                  k_q     <= '0;
                  state_q <= S_DUMP_RD;
               end
            end
            S_DUMP_RD: state_q <= S_DUMP_OUT;
            S_DUMP_OUT: begin
               if (m_ready) begin
                  if (k_q == LAST_ADDR) begin
                     done_q  <= 1'b1;
                     k_q     <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     state_q <= S_DUMP_RD;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   ram_port_mux #(
      .W_INSTR (W_INSTR),
      .W_DATA  (W_DATA)
   ) u_mux (
      .grant_cpu_i       (grant_cpu),
      .ctrl_iram_addr_i  (k_q[W_ADDR-1:0]),
      .ctrl_iram_we_i    ((state_q == S_LOAD_HI) && s_valid),
      .ctrl_iram_din_i   ({s_data, lo_q}),
      .ctrl_dram_addr_i  (k_q[W_ADDR-1:0]),
      .ctrl_dram_write_i (1'b0),
      .ctrl_dram_din_i   ('0),
      .cpu_iram_addr_i   (cpu_iram_addr),
      .cpu_dram_addr_i   (cpu_dram_addr),
      .cpu_dram_din_i    (cpu_dram_din),
      .cpu_dram_write_i  (cpu_dram_write),
      .iram_addr_o       (iram_addr),
      .iram_we_o         (iram_we),
      .iram_din_o        (iram_din),
      .dram_addr_o       (dram_addr),
      .dram_write_o      (dram_write),
      .dram_din_o        (dram_din)
   );

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboard bench for boot_ctrl: directed loads, CPU run, DRAM dump and reset abort.
module tb_boot_ctrl;

   logic        clk;
   logic        rstn;
   logic        s_valid, s_ready;
   logic [7:0]  s_data;
   logic        m_valid, m_ready;
   logic [7:0]  m_data;
   logic        cpu_start, cpu_idle;
   logic [7:0]  cpu_iram_addr, cpu_dram_addr, cpu_dram_din;
   logic        cpu_dram_write;
   logic [7:0]  iram_addr;
   logic        iram_we;
   logic [15:0] iram_din;
   logic [7:0]  dram_addr;
   logic        dram_write;
   logic [7:0]  dram_din, dram_dout;
   logic        busy, done;

   boot_ctrl #(.W_INSTR(16), .W_DATA(8), .DEPTH(256)) dut (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .cpu_start(cpu_start), .cpu_idle(cpu_idle),
      .cpu_iram_addr(cpu_iram_addr), .cpu_dram_addr(cpu_dram_addr),
      .cpu_dram_din(cpu_dram_din), .cpu_dram_write(cpu_dram_write),
      .iram_addr(iram_addr), .iram_we(iram_we), .iram_din(iram_din),
      .dram_addr(dram_addr), .dram_write(dram_write), .dram_din(dram_din),
      .dram_dout(dram_dout), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory models with one-cycle read latency
   logic [15:0] iram_m [256];
   logic [7:0]  dram_m [256];
   logic        preload;
   always @(posedge clk) begin
      if (iram_we) iram_m[iram_addr] <= iram_din;
   end
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) dram_m[i] <= 8'(i);
      end else if (dram_write) begin
         dram_m[dram_addr] <= dram_din;
      end
      dram_dout <= dram_m[dram_addr];
   end

   int checks = 0;
   int passed = 0;
   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endfunction

   logic [7:0] exp_q [$];
   logic [7:0] exp_dram [256];

   int start_cnt = 0, start_cyc = -1, done_cnt = 0, done_cyc = -1, first_mv = -1, pops = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] held = 8'h00;

   // Monitor: pops the scoreboard on every dump transfer, checks hold-stability
   always @(negedge clk) begin
      if (rstn) begin
         if (cpu_start) begin start_cnt++; start_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (m_valid && first_mv < 0) first_mv = cyc;
         if (m_valid && stall_prev) chk("m_data_stable", m_data, held);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("dump_unexpected", 1, 0);
            else chk("dump_byte", m_data, exp_q.pop_front());
            pops++;
         end
         stall_prev = m_valid && !m_ready;
         held       = m_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   logic rnd_mode;
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_byte(input logic [7:0] b, output int xc);
      s_valid = 1'b1;
      s_data  = b;
      xc      = -1;
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         if (s_ready) begin xc = cyc; break; end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (xc < 0) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_done(input int target, input int bound);
      int t = 0;
      while (done_cnt < target && t < bound) begin @(posedge clk); t++; end
      #1;
      if (done_cnt < target) chk("done_timeout", done_cnt, target);
   endtask

   task automatic push_dump();
      for (int i = 0; i < 256; i++) exp_q.push_back(exp_dram[i]);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_s_ready"}, s_ready, 1);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_cpu_start"}, cpu_start, 0);
      chk({tag, "_iram_we"}, iram_we, 0);
      chk({tag, "_dram_write"}, dram_write, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_iram_addr"}, iram_addr, 0);
      chk({tag, "_dram_addr"}, dram_addr, 0);
   endtask

   task automatic cpu_run(input int hold);
      int t = 0;
      while (!cpu_start && t < 50) begin @(posedge clk); #1; t++; end
      if (!cpu_start) chk("cpu_start_seen", 0, 1);
      @(posedge clk); #1;
      cpu_iram_addr  = 8'h77;
      cpu_dram_addr  = 8'h10;
      cpu_dram_din   = 8'h5A;
      cpu_dram_write = 1'b1;
      #1;
      chk("run_iram_addr", iram_addr, 8'h77);
      chk("run_iram_we", iram_we, 0);
      chk("run_dram_addr", dram_addr, 8'h10);
      chk("run_dram_write", dram_write, 1);
      chk("run_s_ready", s_ready, 0);
      @(posedge clk); #1;
      cpu_dram_write = 1'b0;
      repeat (hold - 2) @(posedge clk);
      #1;
      cpu_idle = 1'b1;
   endtask

   initial begin
      int c0, xc, xc_extra, sb, db, base, t;
      rstn = 1'b0; preload = 1'b1; rnd_mode = 1'b0;
      s_valid = 1'b0; s_data = 8'h00; cpu_idle = 1'b1;
      cpu_iram_addr = 8'h00; cpu_dram_addr = 8'h00; cpu_dram_din = 8'h00; cpu_dram_write = 1'b0;
      for (int i = 0; i < 256; i++) exp_dram[i] = 8'(i);
      repeat (2) @(posedge clk);
      #1;
      preload = 1'b0;
      check_reset("rst0");
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      // N=3 with cpu_idle held high
      sb = start_cnt; db = done_cnt;
      push_dump();
      send_byte(8'd3, c0);
      send_byte(8'h34, xc); send_byte(8'h12, xc);
      send_byte(8'h00, xc); send_byte(8'h00, xc);
      send_byte(8'hCD, xc); send_byte(8'hAB, xc);
      wait_done(db + 1, 1500);
      repeat (3) @(posedge clk);
      #1;
      chk("A_start_pulses", start_cnt - sb, 1);
      chk("A_start_cycle", start_cyc - c0, 7);
      chk("A_run_len", first_mv - start_cyc, 4);
      chk("A_iram0", iram_m[0], 16'h1234);
      chk("A_iram1", iram_m[1], 16'h0000);
      chk("A_iram2", iram_m[2], 16'hABCD);
      chk("A_done_pulses", done_cnt - db, 1);
      chk("A_busy_idle", busy, 0);
      chk("A_queue_empty", exp_q.size(), 0);

      // N=256, CPU busy 20 cycles writing DRAM[0x10], back-pressured dump, host byte stalled
      db = done_cnt;
      rnd_mode = 1'b1;
      cpu_idle = 1'b0;
      exp_dram[16] = 8'h5A;
      push_dump();
      send_byte(8'h00, xc);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i), xc);
         send_byte(~8'(i), xc);
      end
      fork
         send_byte(8'h01, xc_extra);
         cpu_run(20);
         wait_done(db + 1, 4000);
      join
      rnd_mode = 1'b0;
      chk("B_extra_byte_cycle", xc_extra, done_cyc);
      chk("B_done_pulses", done_cnt - db, 1);
      chk("B_queue_empty", exp_q.size(), 0);
      for (int i = 0; i < 256; i++) chk("B_iram", iram_m[i], {~8'(i), 8'(i)});

      // Count byte 0x01 already taken; finish the word, then reset mid-dump
      db = done_cnt;
      push_dump();
      send_byte(8'hEF, xc); send_byte(8'hBE, xc);
      base = pops; t = 0;
      while (pops < base + 100 && t < 2000) begin @(posedge clk); t++; end
      if (pops < base + 100) chk("C_dump_progress", pops - base, 100);
      #3 rstn = 1'b0;
      #1;
      check_reset("rst_mid");
      exp_q.delete();
      chk("C_no_done", done_cnt - db, 0);
      chk("C_iram0", iram_m[0], 16'hBEEF);
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      // Fresh N=1 load after the abort
      db = done_cnt;
      push_dump();
      send_byte(8'd1, xc); send_byte(8'h21, xc); send_byte(8'h43, xc);
      wait_done(db + 1, 1500);
      repeat (3) @(posedge clk);
      #1;
      chk("D_iram0", iram_m[0], 16'h4321);
      chk("D_iram1_kept", iram_m[1], 16'hFE01);
      chk("D_done_pulses", done_cnt - db, 1);
      chk("D_busy_idle", busy, 0);
      chk("D_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Host-side boot and run sequencer for the CPU subsystem, sitting between a byte-stream host link and the CPU's IRAM/DRAM ports. It loads a program into IRAM from the input stream, pulses `cpu_start`, and waits for `cpu_idle`. It then streams the full DRAM contents out in address order and returns to idle for the next program. It owns the RAM address/write muxes and grants them to the CPU only while the program runs.

## Interface
- `W_INSTR`, 16: IRAM word width; fixed at 2 bytes.
- `W_DATA`, 8: DRAM word width and stream byte width.
- `DEPTH`, 256: IRAM and DRAM depth; power of two, ≤256.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 8: host input stream; a transfer occurs when valid & ready.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 8: DRAM dump output stream.
- `cpu_start` out 1, `cpu_idle` in 1: CPU control.
- `cpu_iram_addr` in 8, `cpu_dram_addr` in 8, `cpu_dram_din` in 8, `cpu_dram_write` in 1: CPU memory requests.
- `iram_addr` out 8, `iram_we` out 1, `iram_din` out 16: IRAM port (1-cycle read latency; `iram_dout` is wired directly to the CPU).
- `dram_addr` out 8, `dram_write` out 1, `dram_din` out 8, `dram_dout` in 8: DRAM port (1-cycle read latency; `dram_dout` is also wired to the CPU).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse when the last dump byte transfers.

## Operation
- States: IDLE, LOAD_LO, LOAD_HI, START, RUN, DUMP_RD, DUMP_OUT.
- IDLE: `s_ready`=1. On a transfer, latch N=`s_data`; N=0 means 256 words. Set k=0 and go to LOAD_LO.
- LOAD_LO: `s_ready`=1. On a transfer, latch `lo`=`s_data` and go to LOAD_HI.
- LOAD_HI: `s_ready`=1. On a transfer, in the same cycle `iram_we`=1, `iram_addr`=k, `iram_din`={`s_data`,`lo`}.
  - If k==N-1, go to START with k cleared.
  - Otherwise k++ and go to LOAD_LO.
- START: `cpu_start`=1 for exactly one cycle, then RUN.
- RUN: the mux grants the CPU. `iram_addr`=`cpu_iram_addr`, `iram_we`=0, and the DRAM signals come from the `cpu_*` inputs.
  - `cpu_idle` is ignored in the first RUN cycle, which masks the stale idle before the CPU reacts.
  - From the second RUN cycle on, `cpu_idle`=1 moves to DUMP_RD with k=0.
- DUMP_RD: `dram_addr`=k, `dram_write`=0, then DUMP_OUT.
- DUMP_OUT: `dram_addr`=k (held), `m_valid`=1, `m_data`=`dram_dout`. Hold until `m_ready`.
  - On a transfer with k==DEPTH-1: `done`=1 and go to IDLE.
  - Otherwise k++ and go to DUMP_RD.
- Outside START/RUN, the controller owns both ports.
  - Default `iram_addr`=k, `iram_we`=0, `dram_write`=0, `dram_addr`=k.
  - The `cpu_*` inputs are ignored.
- Counters: k is 9 bits to cover N=256. The IRAM address is k[7:0]. The load does not wrap; loading stops at N.
- IRAM words at addresses ≥N keep their previous contents. The DRAM is not cleared between runs.
- `s_ready`=0 in START, RUN, DUMP_RD and DUMP_OUT. Host bytes arriving then are back-pressured, not dropped.

## Timing
- Reset (asynchronous, `rstn`=0) forces state=IDLE, k=0, N=0, `lo`=0.
- Output values during reset:
  - `s_ready`=1.
  - `m_valid`, `cpu_start`, `iram_we`, `dram_write`, `done` all 0.
  - `busy`=0.
  - `iram_addr`=0, `dram_addr`=0.
- All outputs are decoded from registered state and counters, plus the same-cycle write strobes. There are no combinational paths from `m_ready` or `cpu_idle` to outputs.
- Load costs 1 cycle per byte at full host rate: 2N+1 cycles from the first count byte to START.
- `cpu_start` is asserted on the cycle after the final LOAD_HI transfer.
- Dump throughput is 2 cycles per byte with `m_ready` held high, so 512 cycles for DEPTH=256. `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Reset mid-run or mid-dump aborts immediately. No partial stream is resumed; the next stream starts with a count byte.
- `cpu_idle` held at 1 throughout RUN gives a RUN length of exactly 2 cycles.

## Structure
- Shared package `boot_pkg`:
  - `boot_state_e` enum.
  - Localparams `W_ADDR`=$clog2(DEPTH) and `W_CNT`=W_ADDR+1.
- One sub-module is natural: `ram_port_mux`, a combinational grant mux between the controller and the CPU for the IRAM/DRAM address, data and write signals, selected by `grant_cpu` = (state==START or RUN).
- The FSM and counters stay in `boot_ctrl`.

## Test plan
- N=3, words 0x1234, 0x0000, 0xABCD, with `cpu_idle` held 1 → IRAM[0..2] = 0x1234, 0x0000, 0xABCD. Exactly one `cpu_start` pulse, on cycle 7 after the count byte. RUN lasts 2 cycles.
- Count byte 0x00 → 256 words loaded, and addr 255 written. A further host byte is stalled (`s_ready`=0) until the dump completes.
- Preload DRAM[i]=i; the CPU holds `cpu_idle`=0 for 20 cycles → the dump emits 0,1,…,255 in order, `done` pulses once, and the state returns to IDLE.
- Random `m_ready` back-pressure (50%) during the dump → no byte is lost or duplicated, and `m_data` is stable while stalled.
- During RUN, the CPU writes DRAM[0x10]=0x5A → the dump byte 16 is 0x5A. Host bytes sent during RUN are not accepted.
- `rstn` pulsed low mid-dump at k=100 → outputs take their reset values asynchronously. A new load with N=1 then completes normally.
